// File: rtl/reg_src_pkg.sv
// ============================================================================
// reg_src_pkg: opcode/func encodings and sequencer state type
// Revision: 1.0
// ============================================================================
`default_nettype none

package reg_src_pkg;

    localparam logic [3:0] OP_SHIFT    = 4'b0000;
    localparam logic [3:0] OP_LWD      = 4'b0001;
    localparam logic [3:0] OP_STRWD    = 4'b0010;
    localparam logic [3:0] OP_JMP      = 4'b0011;
    localparam logic [3:0] OP_BRNCHEQ  = 4'b0100;
    localparam logic [3:0] OP_BRNCHNEQ = 4'b0101;
    localparam logic [3:0] OP_LORIMD   = 4'b0110;
    localparam logic [3:0] OP_LNANDIMD = 4'b0111;
    localparam logic [3:0] OP_ADDREG   = 4'b1000;
    localparam logic [3:0] OP_ADDSEIMD = 4'b1001;
    localparam logic [3:0] OP_ADDZEIMD = 4'b1010;
    localparam logic [3:0] OP_LNAND    = 4'b1011;
    localparam logic [3:0] OP_SUBREG   = 4'b1100;
    localparam logic [3:0] OP_SUBSEIMD = 4'b1101;
    localparam logic [3:0] OP_SUBZEIMD = 4'b1110;
    localparam logic [3:0] OP_LOR      = 4'b1111;

    localparam logic [1:0] FUNC_SHL = 2'b01;
    localparam logic [1:0] FUNC_SHR = 2'b10;
    localparam logic [1:0] FUNC_SAR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/reg_src_decode.sv
// ============================================================================
// reg_src_decode: opcode/func to source-field mask {c,b,a}
// Revision: 1.0
// ============================================================================
`default_nettype none

module reg_src_decode
    import reg_src_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [1:0] func,
    output logic [2:0] src_mask
);

    always_comb begin
        src_mask = 3'b000;
        case (opcode)
            OP_ADDREG, OP_SUBREG, OP_LNAND, OP_LOR, OP_LWD:
                src_mask = 3'b110;
            OP_ADDSEIMD, OP_ADDZEIMD, OP_SUBSEIMD, OP_SUBZEIMD,
            OP_LNANDIMD, OP_LORIMD:
                src_mask = 3'b010;
            // func 00 is the shift no-op and reads nothing
            OP_SHIFT:
                if (func == FUNC_SHL || func == FUNC_SHR || func == FUNC_SAR)
                    src_mask = 3'b110;
            OP_BRNCHEQ, OP_BRNCHNEQ:
                src_mask = 3'b011;
            OP_STRWD:
                src_mask = 3'b111;
            default:
                src_mask = 3'b000;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/reg_src_sequencer.sv
// ============================================================================
// reg_src_sequencer: schedules source-register reads over RD_PORTS ports
// Revision: 1.0
// ============================================================================
`default_nettype none

module reg_src_sequencer
    import reg_src_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int RADDR_W  = 4,
    parameter int RD_PORTS = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [4+3*RADDR_W-1:0]       in_instr,
    output logic [RD_PORTS-1:0]          rf_ren,
    output logic [RD_PORTS*RADDR_W-1:0]  rf_raddr,
    input  logic [RD_PORTS*DATA_W-1:0]   rf_rdata,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [4+3*RADDR_W-1:0]       out_instr,
    output logic [DATA_W-1:0]            op_a,
    output logic [DATA_W-1:0]            op_b,
    output logic [DATA_W-1:0]            op_c,
    output logic [2:0]                   op_used
);

    localparam int INSTR_W = 4 + 3*RADDR_W;

    logic [2:0][RADDR_W-1:0] fld_addr;
    logic [2:0]              mask;
    logic                    accept;

    assign fld_addr[0] = in_instr[3*RADDR_W-1 -: RADDR_W];
    assign fld_addr[1] = in_instr[2*RADDR_W-1 -: RADDR_W];
    assign fld_addr[2] = in_instr[RADDR_W-1:0];

    reg_src_decode u_decode (
        .opcode   (in_instr[INSTR_W-1 -: 4]),
        .func     (in_instr[1:0]),
        .src_mask (mask)
    );

    // Compacted issue list: used, non-zero fields in a, b, c order
    logic [2:0][RADDR_W-1:0] new_addr;
    logic [2:0][1:0]         new_fld;
    logic [1:0]              new_n;

    always_comb begin
        new_addr = '0;
        new_fld  = '0;
        new_n    = 2'd0;
        for (int i = 0; i < 3; i++) begin
            if (mask[i] && !(ZERO_REG != 0 && fld_addr[i] == '0)) begin
                new_addr[new_n] = fld_addr[i];
                new_fld[new_n]  = 2'(i);
                new_n           = new_n + 2'd1;
            end
        end
    end

    state_t                       state_q, state_d;
    logic                         rdy_q;
    logic [2:0]                   base_q, base_d;
    logic [1:0]                   n_q, n_d;
    logic [2:0][RADDR_W-1:0]      list_addr_q, list_addr_d;
    logic [2:0][1:0]              list_fld_q, list_fld_d;
    logic [RD_PORTS-1:0]          rf_ren_q, rf_ren_d;
    logic [RD_PORTS*RADDR_W-1:0]  rf_raddr_q, rf_raddr_d;
    logic [RD_PORTS-1:0][1:0]     rf_fld_q, rf_fld_d;
    logic [RD_PORTS-1:0]          pend_en_q, pend_en_d;
    logic [RD_PORTS-1:0][1:0]     pend_fld_q, pend_fld_d;
    logic [INSTR_W-1:0]           instr_q, instr_d;
    logic [2:0]                   used_q, used_d;
    logic [2:0][DATA_W-1:0]       op_q, op_d;

    logic [2:0][RADDR_W-1:0]      src_addr;
    logic [2:0][1:0]              src_fld;
    logic [1:0]                   src_n;
    logic [2:0]                   src_base;
    logic [2:0]                   idx;
    logic                         issue;

    assign in_ready = rdy_q & ((state_q == IDLE) | ((state_q == OUT) & out_ready));
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        n_d         = n_q;
        list_addr_d = list_addr_q;
        list_fld_d  = list_fld_q;
        instr_d     = instr_q;
        used_d      = used_q;
        op_d        = op_q;
        rf_ren_d    = '0;
        rf_raddr_d  = '0;
        rf_fld_d    = '0;
        pend_en_d   = rf_ren_q;
        pend_fld_d  = rf_fld_q;
        src_addr    = list_addr_q;
        src_fld     = list_fld_q;
        src_n       = n_q;
        src_base    = base_q + 3'(RD_PORTS);
        idx         = '0;
        issue       = 1'b0;

        case (state_q)
            ISSUE: begin
                if (src_base < {1'b0, n_q}) issue = 1'b1;
                else                        state_d = DRAIN;
            end
            DRAIN:   state_d = OUT;
            OUT:     if (out_ready) state_d = IDLE;
            default: ;
        endcase

        if (accept) begin
            src_addr    = new_addr;
            src_fld     = new_fld;
            src_n       = new_n;
            src_base    = 3'd0;
            list_addr_d = new_addr;
            list_fld_d  = new_fld;
            n_d         = new_n;
            instr_d     = in_instr;
            used_d      = mask;
            op_d        = '0;
            issue       = (new_n != 2'd0);
            state_d     = (new_n != 2'd0) ? ISSUE : OUT;
        end

        if (issue) begin
            base_d = src_base;
            for (int p = 0; p < RD_PORTS; p++) begin
                idx = src_base + 3'(p);
                if (idx < {1'b0, src_n}) begin
                    rf_ren_d[p]                        = 1'b1;
                    rf_raddr_d[p*RADDR_W +: RADDR_W]   = src_addr[idx[1:0]];
                    rf_fld_d[p]                        = src_fld[idx[1:0]];
                end
            end
        end

        // Read data lands one cycle after its issue; route it to its field
        for (int p = 0; p < RD_PORTS; p++) begin
            if (pend_en_q[p]) op_d[pend_fld_q[p]] = rf_rdata[p*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rdy_q       <= 1'b0;
            base_q      <= '0;
            n_q         <= '0;
            list_addr_q <= '0;
            list_fld_q  <= '0;
            rf_ren_q    <= '0;
            rf_raddr_q  <= '0;
            rf_fld_q    <= '0;
            pend_en_q   <= '0;
            pend_fld_q  <= '0;
            instr_q     <= '0;
            used_q      <= '0;
            op_q        <= '0;
        end else begin
            state_q     <= state_d;
            rdy_q       <= 1'b1;
            base_q      <= base_d;
            n_q         <= n_d;
            list_addr_q <= list_addr_d;
            list_fld_q  <= list_fld_d;
            rf_ren_q    <= rf_ren_d;
            rf_raddr_q  <= rf_raddr_d;
            rf_fld_q    <= rf_fld_d;
            pend_en_q   <= pend_en_d;
            pend_fld_q  <= pend_fld_d;
            instr_q     <= instr_d;
            used_q      <= used_d;
            op_q        <= op_d;
        end
    end

    assign rf_ren    = rf_ren_q;
    assign rf_raddr  = rf_raddr_q;
    assign out_valid = (state_q == OUT);
    assign out_instr = instr_q;
    assign op_a      = op_q[0];
    assign op_b      = op_q[1];
    assign op_c      = op_q[2];
    assign op_used   = used_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_src_sequencer.sv
// ============================================================================
// tb_reg_src_sequencer: directed vectors on 2-port and 1-port sequencers
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_reg_src_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, out_ready;
    logic [15:0] in_instr;

    logic        in_ready2, out_valid2;
    logic [1:0]  ren2;
    logic [7:0]  raddr2;
    logic [31:0] rdata2;
    logic [15:0] oinstr2, a2, b2, c2;
    logic [2:0]  used2;

    logic        in_ready1, out_valid1;
    logic [0:0]  ren1;
    logic [3:0]  raddr1;
    logic [15:0] rdata1;
    logic [15:0] oinstr1, a1, b1, c1;
    logic [2:0]  used1;

    always #5 clk = ~clk;

    reg_src_sequencer #(.RD_PORTS(2)) u_p2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .in_instr(in_instr), .rf_ren(ren2), .rf_raddr(raddr2), .rf_rdata(rdata2),
        .out_valid(out_valid2), .out_ready(out_ready), .out_instr(oinstr2),
        .op_a(a2), .op_b(b2), .op_c(c2), .op_used(used2)
    );

    reg_src_sequencer #(.RD_PORTS(1)) u_p1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
        .in_instr(in_instr), .rf_ren(ren1), .rf_raddr(raddr1), .rf_rdata(rdata1),
        .out_valid(out_valid1), .out_ready(out_ready), .out_instr(oinstr1),
        .op_a(a1), .op_b(b1), .op_c(c1), .op_used(used1)
    );

    function automatic logic [15:0] rfval(input logic [3:0] a);
        if (a == 4'd2)      return 16'h00AA;
        else if (a == 4'd3) return 16'h00BB;
        else                return {8'hC0, a, a};
    endfunction

    // Register-file model: data one cycle after enable, junk otherwise
    always @(posedge clk) begin
        for (int p = 0; p < 2; p++)
            rdata2[p*16 +: 16] <= ren2[p] ? rfval(raddr2[p*4 +: 4]) : 16'hDEAD;
        rdata1 <= ren1[0] ? rfval(raddr1) : 16'hDEAD;
    end

    int          cyc = 0;
    int          ov_cnt[2]   = '{0, 0};
    int          ov_last[2]  = '{0, 0};
    int          iss_cnt[2]  = '{0, 0};
    int          iss_start[2] = '{0, 0};
    int          addr_cnt[2] = '{0, 0};
    logic [11:0] seq[2]      = '{12'h0, 12'h0};
    logic [1:0]  prev_ov     = 2'b00;
    logic [1:0]  prev_iss    = 2'b00;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (ren2 != 2'b00) begin
            if (!prev_iss[0]) iss_start[0] = cyc;
            iss_cnt[0]++;
            for (int p = 0; p < 2; p++)
                if (ren2[p]) begin
                    seq[0] = {seq[0][7:0], raddr2[p*4 +: 4]};
                    addr_cnt[0]++;
                end
        end
        if (ren1[0]) begin
            if (!prev_iss[1]) iss_start[1] = cyc;
            iss_cnt[1]++;
            seq[1] = {seq[1][7:0], raddr1};
            addr_cnt[1]++;
        end
        if (out_valid2 && !prev_ov[0]) begin ov_cnt[0]++; ov_last[0] = cyc; end
        if (out_valid1 && !prev_ov[1]) begin ov_cnt[1]++; ov_last[1] = cyc; end
        prev_ov  = {out_valid1, out_valid2};
        prev_iss = {ren1[0], ren2 != 2'b00};
    end

    typedef struct {
        logic [15:0] instr;
        logic [2:0]  used;
        logic [15:0] a, b, c;
        int          n;
        logic [11:0] addrs;
        int          b2, lat2, b1, lat1;
    } vec_t;

    vec_t vecs[13];
    int   total = 0;
    int   bad   = 0;
    int   t_acc;
    int   s_ov[2], s_iss[2], s_addr[2];

    function automatic vec_t mk(input logic [15:0] instr, input logic [2:0] used,
                                input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] c, input int n,
                                input logic [11:0] addrs, input int bb2,
                                input int lat2, input int bb1, input int lat1);
        vec_t v;
        v.instr = instr; v.used = used; v.a = a; v.b = b; v.c = c;
        v.n = n; v.addrs = addrs; v.b2 = bb2; v.lat2 = lat2; v.b1 = bb1; v.lat1 = lat1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic snap();
        for (int i = 0; i < 2; i++) begin
            s_ov[i] = ov_cnt[i]; s_iss[i] = iss_cnt[i]; s_addr[i] = addr_cnt[i];
        end
    endtask

    task automatic start(input vec_t v, input logic rdy);
        @(negedge clk);
        in_instr  = v.instr;
        in_valid  = 1'b1;
        out_ready = rdy;
        #1;
        chk($sformatf("p2 in_ready %h", v.instr), 32'(in_ready2), 32'd1);
        chk($sformatf("p1 in_ready %h", v.instr), 32'(in_ready1), 32'd1);
        t_acc = cyc;
        snap();
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic check_dut(input int i, input vec_t v);
        logic [15:0] a, b, c, oi;
        logic [2:0]  u;
        logic [11:0] m;
        int          lat, nb;
        string       s;
        s = $sformatf("p%0d %h", (i == 0) ? 2 : 1, v.instr);
        if (i == 0) begin a = a2; b = b2; c = c2; oi = oinstr2; u = used2; lat = v.lat2; nb = v.b2; end
        else        begin a = a1; b = b1; c = c1; oi = oinstr1; u = used1; lat = v.lat1; nb = v.b1; end
        chk({s, " op_used"}, 32'(u), 32'(v.used));
        chk({s, " op_a"}, 32'(a), 32'(v.a));
        chk({s, " op_b"}, 32'(b), 32'(v.b));
        chk({s, " op_c"}, 32'(c), 32'(v.c));
        chk({s, " out_instr"}, 32'(oi), 32'(v.instr));
        chk({s, " out_valid rises"}, 32'(ov_cnt[i] - s_ov[i]), 32'd1);
        chk({s, " latency"}, 32'(ov_last[i] - t_acc), 32'(lat));
        chk({s, " issue cycles"}, 32'(iss_cnt[i] - s_iss[i]), 32'(nb));
        chk({s, " issued addrs"}, 32'(addr_cnt[i] - s_addr[i]), 32'(v.n));
        if (v.n > 0) begin
            m = (v.n == 3) ? 12'hFFF : (v.n == 2) ? 12'h0FF : 12'h00F;
            chk({s, " first issue"}, 32'(iss_start[i] - t_acc), 32'd1);
            chk({s, " addr order"}, 32'(seq[i] & m), 32'(v.addrs));
        end
    endtask

    task automatic finish(input vec_t v, input logic release_out);
        for (int k = 0; k < 20 && !((ov_cnt[0] > s_ov[0]) && (ov_cnt[1] > s_ov[1])); k++)
            @(negedge clk);
        if (!((ov_cnt[0] > s_ov[0]) && (ov_cnt[1] > s_ov[1])))
            chk($sformatf("timeout %h", v.instr), 32'd0, 32'd1);
        check_dut(0, v);
        check_dut(1, v);
        if (release_out) begin
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    initial begin
        //            instr     used   a         b         c         n  addrs   b2 l2 b1 l1
        vecs[0]  = mk(16'h8123, 3'h6, 16'h0000, 16'h00AA, 16'h00BB, 2, 12'h023, 1, 3, 2, 4);
        vecs[1]  = mk(16'h2456, 3'h7, 16'hC044, 16'hC055, 16'hC066, 3, 12'h456, 2, 4, 3, 5);
        vecs[2]  = mk(16'h3123, 3'h0, 16'h0000, 16'h0000, 16'h0000, 0, 12'h000, 0, 1, 0, 1);
        vecs[3]  = mk(16'h0124, 3'h0, 16'h0000, 16'h0000, 16'h0000, 0, 12'h000, 0, 1, 0, 1);
        vecs[4]  = mk(16'h1307, 3'h6, 16'h0000, 16'h0000, 16'hC077, 1, 12'h007, 1, 3, 1, 3);
        vecs[5]  = mk(16'h0A59, 3'h6, 16'h0000, 16'hC055, 16'hC099, 2, 12'h059, 1, 3, 2, 4);
        vecs[6]  = mk(16'h4082, 3'h3, 16'h0000, 16'hC088, 16'h0000, 1, 12'h008, 1, 3, 1, 3);
        vecs[7]  = mk(16'h9ABC, 3'h2, 16'h0000, 16'hC0BB, 16'h0000, 1, 12'h00B, 1, 3, 1, 3);
        vecs[8]  = mk(16'h5E0F, 3'h3, 16'hC0EE, 16'h0000, 16'h0000, 1, 12'h00E, 1, 3, 1, 3);
        vecs[9]  = mk(16'h2000, 3'h7, 16'h0000, 16'h0000, 16'h0000, 0, 12'h000, 0, 1, 0, 1);
        vecs[10] = mk(16'h7123, 3'h2, 16'h0000, 16'h00AA, 16'h0000, 1, 12'h002, 1, 3, 1, 3);
        vecs[11] = mk(16'hF3C5, 3'h6, 16'h0000, 16'hC0CC, 16'hC055, 2, 12'h0C5, 1, 3, 2, 4);
        vecs[12] = mk(16'hF127, 3'h6, 16'h0000, 16'h00AA, 16'hC077, 2, 12'h027, 1, 3, 2, 4);

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_instr = 16'h0;
        #2;
        chk("rst p2 in_ready",  32'(in_ready2),  32'd0);
        chk("rst p1 in_ready",  32'(in_ready1),  32'd0);
        chk("rst p2 out_valid", 32'(out_valid2), 32'd0);
        chk("rst p1 out_valid", 32'(out_valid1), 32'd0);
        chk("rst p2 rf_ren",    32'(ren2),       32'd0);
        chk("rst p1 rf_ren",    32'(ren1),       32'd0);
        chk("rst p2 op_used",   32'(used2),      32'd0);
        chk("rst p2 out_instr", 32'(oinstr2),    32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post-rst p2 in_ready", 32'(in_ready2), 32'd1);
        chk("post-rst p1 in_ready", 32'(in_ready1), 32'd1);

        for (int v = 0; v <= 10; v++) begin
            start(vecs[v], 1'b0);
            finish(vecs[v], 1'b1);
        end

        // Output stall, then back-to-back accept from OUT
        start(vecs[11], 1'b0);
        finish(vecs[11], 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall p2 out_valid", 32'(out_valid2), 32'd1);
            chk("stall p1 out_valid", 32'(out_valid1), 32'd1);
            chk("stall p2 op_b",      32'(b2),         32'hC0CC);
            chk("stall p2 op_c",      32'(c2),         32'hC055);
            chk("stall p1 op_c",      32'(c1),         32'hC055);
            chk("stall p2 out_instr", 32'(oinstr2),    32'hF3C5);
            chk("stall p2 op_used",   32'(used2),      32'h6);
        end
        start(vecs[12], 1'b1);
        chk("b2b p2 rf_ren",    32'(ren2),       32'h3);
        chk("b2b p2 rf_raddr",  32'(raddr2),     32'h72);
        chk("b2b p2 out_valid", 32'(out_valid2), 32'd0);
        chk("b2b p1 rf_raddr",  32'(raddr1),     32'h2);
        finish(vecs[12], 1'b1);

        // Reset during ISSUE of a strwd
        start(vecs[1], 1'b0);
        chk("pre-rst p2 rf_ren", 32'(ren2), 32'h3);
        reset = 1'b1;
        #1;
        chk("midrst p2 rf_ren",    32'(ren2),       32'd0);
        chk("midrst p1 rf_ren",    32'(ren1),       32'd0);
        chk("midrst p2 out_valid", 32'(out_valid2), 32'd0);
        chk("midrst p1 in_ready",  32'(in_ready1),  32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("after-rst p2 in_ready", 32'(in_ready2), 32'd1);
        chk("after-rst p1 in_ready", 32'(in_ready1), 32'd1);
        snap();
        repeat (8) @(negedge clk);
        chk("after-rst p2 no out_valid", 32'(ov_cnt[0] - s_ov[0]),  32'd0);
        chk("after-rst p1 no out_valid", 32'(ov_cnt[1] - s_ov[1]),  32'd0);
        chk("after-rst p2 no issue",     32'(iss_cnt[0] - s_iss[0]), 32'd0);
        chk("after-rst p1 no issue",     32'(iss_cnt[1] - s_iss[1]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/reg_src_sequencer.md
# reg_src_sequencer

Sequential register-operand fetch unit sitting between instruction decode and execute. It replaces the fixed per-opcode source-select decode with three steps. First, it derives which of the three instruction register fields (ra, rb, rc) each opcode and func actually reads. Second, it schedules those reads over a parametrised number of synchronous register-file read ports, spreading them across multiple cycles when ports are scarce. Third, it presents the collected operands to execute under a valid/ready handshake.

## Interface
- DATA_W, 16: register data width.
- RADDR_W, 4: register address width. Instruction fields are ra=instr[11:8], rb=instr[7:4], rc=instr[3:0], func=instr[1:0] for RADDR_W=4. Fields are placed contiguously below the 4-bit opcode for other widths.
- RD_PORTS, 2: register-file read ports, legal range 1..3.
- ZERO_REG, 1: when 1, register 0 reads as zero and is never issued to the register file.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  instruction available.
- in_ready  out  1  block can accept an instruction.
- in_instr  in  4+3*RADDR_W  instruction word, opcode in the top 4 bits.
- rf_ren  out  RD_PORTS  per-port read enable.
- rf_raddr  out  RD_PORTS*RADDR_W  per-port read address.
- rf_rdata  in  RD_PORTS*DATA_W  per-port read data, valid one cycle after the port's rf_ren.
- out_valid  out  1  operands complete.
- out_ready  in  1  execute accepts.
- out_instr  out  4+3*RADDR_W  latched instruction.
- op_a, op_b, op_c  out  DATA_W each  values of ra, rb, rc.
- op_used  out  3  {c,b,a} flags marking which fields are real sources.

## Operation
- Source masks {c,b,a}, decided per opcode:
  - addreg, subreg, lnand, lor: 110.
  - addseimd, addzeimd, subseimd, subzeimd, lnandimd, lorimd: 010.
  - shift with func≠00: 110. shift with func=00: 000, treated as a no-op.
  - brncheq, brnchneq: 011.
  - jmp: 000.
  - lwd: 110.
  - strwd: 111.
  - Unlisted opcodes: 000.
- Issue list:
  - Contains the used fields in order a, b, c.
  - With ZERO_REG=1, a field whose address is 0 is dropped from the list. Its op_x becomes 0 and its op_used bit stays 1.
  - n = list length. Batches b = ceil(n/RD_PORTS).
  - Each batch fills ports from port 0 upward; unused ports have rf_ren=0.
- FSM:
  - IDLE: in_ready=1. On accept, go to ISSUE if n>0, else to OUT.
  - ISSUE: drive one batch per cycle for b cycles, then go to DRAIN.
  - DRAIN: capture the last batch's rf_rdata, then go to OUT.
  - Data from every earlier batch is captured in the cycle after its issue, overlapping with the next issue.
  - OUT: out_valid=1 and outputs held stable. On out_ready, return to IDLE.
  - OUT with out_ready=1 and in_valid=1 accepts the next instruction directly, so in_ready = (state==IDLE) | (state==OUT & out_ready).
- Unused fields: op_x=0 and op_used bit=0.

## Timing
- Cycle numbering: acceptance cycle is T, i.e. in_valid & in_ready high at the end of T.
- Issue cycles are T+1 .. T+b. rf_raddr and rf_ren are registered outputs.
- out_valid first high at T+b+2 when n>0, and at T+1 when n=0.
- Example: strwd with RD_PORTS=1 gives out_valid at T+5. With RD_PORTS=3 it gives T+3.
- rf_ren is never high outside ISSUE.
- Reset values: all outputs 0, state IDLE. in_ready rises the first cycle after reset deasserts.
- Reset asserted mid-ISSUE or mid-DRAIN: the transaction is discarded immediately. rf_ren=0 asynchronously and no out_valid follows.
- out_valid held with out_ready=0: all outputs are frozen indefinitely.

## Structure
- Package reg_src_pkg holds:
  - The opcode constants: addreg=1000, addseimd=1001, addzeimd=1010, subreg=1100, subseimd=1101, subzeimd=1110, shift=0000, lnand=1011, lnandimd=0111, lor=1111, lorimd=0110, brncheq=0100, brnchneq=0101, jmp=0011, lwd=0001, strwd=0010.
  - The func constants: shl=01, shr=10, sar=11.
  - The FSM state enum: IDLE, ISSUE, DRAIN, OUT.
- Sub-module reg_src_decode: combinational opcode/func to 3-bit mask, the direct successor of the old per-opcode select decode. The sequencer instantiates it once.

## Test plan
- addreg, ra=1, rb=2, rc=3, RD_PORTS=2, RF returns 16'h00AA and 16'h00BB -> one issue cycle with addresses {2,3}; out_valid at T+3; op_b=00AA, op_c=00BB, op_used=110.
- strwd with fields 4, 5, 6 under RD_PORTS=1 -> three single-port issue cycles in the order 4, 5, 6; out_valid at T+5; op_used=111.
- jmp, then shift with func=00 -> no rf_ren; out_valid at T+1; op_used=000.
- ZERO_REG=1, lwd with rb=0, rc=7 -> one issue of address 7 only; op_b=0, op_used=110.
- out_ready low for 5 cycles, then high with in_valid high and a new lor -> outputs stable throughout the stall; new instruction accepted in the same cycle; its issue starts the next cycle.
- reset pulsed during ISSUE of a strwd -> rf_ren=0 at once; no out_valid; in_ready=1 the cycle after reset deasserts.
